// File: rtl/parity_arb_ctrl.sv
// Two-requester round-robin arbiter that tags the granted word with even and odd parity.
// Optional per-requester handshake counters (cnt0/cnt1) are enabled by defining PARITY_ARB_STATS_EN.
module parity_arb_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_id,
    output logic [DATA_W:0]   data_even,
    output logic [DATA_W:0]   data_odd,
    output logic              busy
`ifdef PARITY_ARB_STATS_EN
    ,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              id_q, id_d;
    logic              last_id_q, last_id_d;
    logic [DATA_W:0]   even_q, even_d;
    logic [DATA_W:0]   odd_q, odd_d;
    logic              grant_id;

    // On a tie the requester that did not win last time is chosen.
    assign grant_id = (req0 && req1) ? ~last_id_q : req1;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        word_d    = word_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        even_d    = even_q;
        odd_d     = odd_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are combinational, so mask them while reset is asserted.
                if ((req0 || req1) && rst_n) begin
                    gnt0      = ~grant_id;
                    gnt1      = grant_id;
                    word_d    = grant_id ? data1 : data0;
                    id_d      = grant_id;
                    last_id_d = grant_id;
                    state_d   = CALC;
                end
            end
            CALC: begin
                even_d  = {^word_q, word_q};
                odd_d   = {~^word_q, word_q};
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            even_q    <= '0;
            odd_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            state_q   <= state_d;
            word_q    <= word_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            even_q    <= even_d;
            odd_q     <= odd_d;
        end
    end

    assign out_id    = id_q;
    assign data_even = even_q;
    assign data_odd  = odd_q;
    assign busy      = (state_q != IDLE);

`ifdef PARITY_ARB_STATS_EN
    logic        handshake;
    logic [15:0] cnt0_q, cnt1_q;

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (handshake) begin
            if (!id_q && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (id_q && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_parity_arb_ctrl.sv
// Scoreboard bench for parity_arb_ctrl: stimulus pushes expected results, a monitor pops them on each handshake.
// Counter checks are compiled only when PARITY_ARB_STATS_EN is defined.
module tb_parity_arb_ctrl;

    typedef struct packed {
        logic       id;
        logic [8:0] even;
        logic [8:0] odd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1;
    logic       out_ready = 1'b1;
    logic       out_valid, out_id, busy;
    logic [8:0] data_even, data_odd;
`ifdef PARITY_ARB_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    parity_arb_ctrl #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .out_ready(out_ready), .out_valid(out_valid), .out_id(out_id),
        .data_even(data_even), .data_odd(data_odd), .busy(busy)
`ifdef PARITY_ARB_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_id", {31'd0, out_id}, {31'd0, e.id});
                check("data_even", {23'd0, data_even}, {23'd0, e.even});
                check("data_odd", {23'd0, data_odd}, {23'd0, e.odd});
            end
        end
    end

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One transaction with out_ready high: checks grant, latency and single-cycle valid.
    task automatic send(input bit id, input logic [7:0] d, input logic [8:0] ev);
        bit ok;
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; data1 = d; end
        else    begin req0 = 1'b1; data0 = d; end
        wait_gnt(ok);
        if (ok) begin
            check("gnt_sel", {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
            q.push_back('{id: id, even: ev, odd: ev ^ 9'h100});
            @(posedge clk); #1;
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            check("calc_valid", {31'd0, out_valid}, 32'd0);
            check("calc_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            @(negedge clk);
            check("valid_drop", {31'd0, out_valid}, 32'd0);
        end else begin
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        logic [7:0] sweep_d [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic [8:0] sweep_e [6] = '{9'h000, 9'h101, 9'h102, 9'h003, 9'h104, 9'h005};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_id", {31'd0, out_id}, 32'd0);
        check("rst_even", {23'd0, data_even}, 32'd0);
        check("rst_odd", {23'd0, data_odd}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request, zero word
        send(1'b0, 8'h00, 9'h000);

        // Parity sweep through requester 1
        for (int i = 0; i < 6; i++) send(1'b1, sweep_d[i], sweep_e[i]);

        // Tie round-robin from reset: 0, 1, 0
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h0F; data1 = 8'h01;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(ok);
            if (!ok) break;
            check("tie_gnt", {30'd0, gnt1, gnt0}, (k % 2) ? 32'd2 : 32'd1);
            if (k % 2) q.push_back('{id: 1'b1, even: 9'h101, odd: 9'h001});
            else       q.push_back('{id: 1'b0, even: 9'h00F, odd: 9'h10F});
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Backpressure with a competing request waiting
        out_ready = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 8'h07;
        wait_gnt(ok);
        if (ok) begin
            check("bp_gnt", {30'd0, gnt1, gnt0}, 32'd1);
            q.push_back('{id: 1'b0, even: 9'h107, odd: 9'h007});
            @(posedge clk); #1;
            req0 = 1'b0; req1 = 1'b1; data1 = 8'h10;
            @(negedge clk);
            check("bp_calc_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            repeat (5) begin
                @(negedge clk);
                check("bp_valid", {31'd0, out_valid}, 32'd1);
                check("bp_even", {23'd0, data_even}, 32'h107);
                check("bp_id", {31'd0, out_id}, 32'd0);
                check("bp_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            q.push_back('{id: 1'b1, even: 9'h110, odd: 9'h010});
            @(negedge clk);
            @(negedge clk);
            check("bp_idle", {31'd0, busy}, 32'd0);
            check("bp_wait_gnt", {30'd0, gnt1, gnt0}, 32'd2);
            @(posedge clk); #1 req1 = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            req0 = 1'b0; out_ready = 1'b1;
        end

        // Reset during CALC, then immediate re-grant
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 8'h33;
        wait_gnt(ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("mid_rst_even", {23'd0, data_even}, 32'd0);
        check("mid_rst_odd", {23'd0, data_odd}, 32'd0);
        check("mid_rst_id", {31'd0, out_id}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_novalid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_cycle_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        q.push_back('{id: 1'b0, even: 9'h033, odd: 9'h133});
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("regrant_valid", {31'd0, out_valid}, 32'd1);
        repeat (2) @(negedge clk);

`ifdef PARITY_ARB_STATS_EN
        do_reset();
        @(negedge clk);
        check("cnt0_rst", {16'd0, cnt0}, 32'd0);
        send(1'b0, 8'h11, 9'h011);
        send(1'b1, 8'h12, 9'h012);
        send(1'b0, 8'h13, 9'h113);
        send(1'b0, 8'h14, 9'h014);
        check("cnt0", {16'd0, cnt0}, 32'd3);
        check("cnt1", {16'd0, cnt1}, 32'd1);
`endif

        // Drain the scoreboard
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        check("drain", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_arb_ctrl.md
PARITY_ARB_CTRL -- requirements
Module: parity_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each requester data word.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-004 The block SHALL have ports req0/req1, input, 1 bit each, the request from requester 0/1.
REQ-005 The block SHALL have ports data0/data1, input, DATA_W each, the word offered by requester 0/1.
REQ-006 The block SHALL have ports gnt0/gnt1, output, 1 bit each, a one-cycle accept pulse to requester 0/1.
REQ-007 The block SHALL have port out_ready, input, 1 bit, indicating the consumer accepts the result this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit, indicating the result is valid.
REQ-009 The block SHALL have port out_id, output, 1 bit, the requester index of the current result.
REQ-010 The block SHALL have port data_even, output, DATA_W+1, the even-parity word {parity bit, data}.
REQ-011 The block SHALL have port data_odd, output, DATA_W+1, the odd-parity word {parity bit, data}.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and HOLD.
REQ-014 IDLE->CALC: with any req high in IDLE, exactly one gnt SHALL assert combinationally in that cycle, and the granted data word and id SHALL be captured at the clock edge.
REQ-015 Arbitration SHALL grant a sole request directly; when both requests are high, it SHALL grant the requester that is not last_id (round-robin).
REQ-016 last_id SHALL update to the granted index on each grant.
REQ-017 CALC->HOLD SHALL be unconditional after 1 cycle; at that edge, data_even SHALL load {^w, w} and data_odd SHALL load {~^w, w}, where w is the captured word.
REQ-018 In HOLD, out_valid SHALL be 1, and data_even, data_odd and out_id SHALL be held stable until out_ready is sampled high.
REQ-019 HOLD->IDLE SHALL occur on out_valid and out_ready; out_valid SHALL fall the next cycle.
REQ-020 Latency SHALL be out_valid high 2 cycles after the gnt cycle; throughput SHALL be at most one word per 3 cycles.
REQ-021 gnt0/gnt1 SHALL be 0 in CALC and HOLD, and requests arriving there SHALL wait without loss.
REQ-022 A req dropped before its gnt SHALL have no effect.
REQ-023 Requesters SHALL hold req and data stable until gnt.
REQ-024 When out_ready is held high in HOLD, out_valid SHALL last exactly 1 cycle.

Reset
REQ-025 When rst_n is low, the state SHALL be IDLE, and out_valid, out_id, busy, gnt0, gnt1, data_even and data_odd SHALL be 0.
REQ-026 When rst_n is low, last_id SHALL be 1, so that requester 0 wins the first tie.
REQ-027 A reset during CALC or HOLD SHALL discard the pending word; the requester SHALL re-request.
REQ-028 After reset deassertion, the first grant SHALL be possible in the first clock cycle.

Configuration
REQ-029 With macro PARITY_ARB_STATS_EN defined, the block SHALL add outputs cnt0 and cnt1 (16 bits each), counting completed handshakes per requester, saturating at 0xFFFF, and reset to 0.
REQ-030 Without PARITY_ARB_STATS_EN defined, the cnt0/cnt1 ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Single request: req0=1, data0=8'h00, out_ready=1 -> gnt0 pulses; 2 cycles later out_valid=1, out_id=0, data_even=9'h000, data_odd=9'h100.
REQ-032 Parity values: an incrementing sweep 8'h00..8'h05 through requester 1 SHALL produce data_even for 8'h01 = 9'h101, for 8'h03 = 9'h003 and for 8'h05 = 9'h005, with data_odd = data_even ^ 9'h100 in every case.
REQ-033 Tie round-robin: req0=req1=1 held after reset -> grants SHALL alternate gnt0, gnt1, gnt0, and out_id SHALL follow 0, 1, 0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HOLD with data0=8'h07 -> out_valid and data_even=9'h107 SHALL stay stable, with no gnt; on out_ready=1, the block SHALL return to IDLE.
REQ-035 Reset mid-operation: rst_n low while in CALC -> all outputs SHALL be 0 immediately, no out_valid SHALL follow, and a re-request SHALL be granted normally.
REQ-036 Stats (PARITY_ARB_STATS_EN): 3 handshakes from requester 0 and 1 from requester 1 -> cnt0=3 and cnt1=1; the counters SHALL saturate at 0xFFFF under a forced long run.
